mux_scan_ctrl: RTL and testbench

- Sequential controller that sits directly upstream of the 4:1 `multiplexer`:
  - drives its `s1`/`s0` selects through all four inputs;
  - waits a settle interval on each input;
  - samples the mux output `y`;
  - packs the four samples into a frame handed downstream over a valid/ready handshake.
- Turns the combinational mux into a scanned 4-channel sampler.
- Runs single-shot or continuous.

---
 rtl/mux_scan_ctrl.sv | 96 +++++++++
 tb/tb_mux_scan_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux through its inputs, samples y after SETTLE cycles each, emits a 4-bit frame.
// Optional frame parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_ctrl #(
  parameter int SETTLE = 2,
  parameter int CW     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       frame_par
`endif
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;
  localparam int SE = (SETTLE < 1) ? 1 : SETTLE;
  localparam logic [CW-1:0] LAST = CW'(SE - 1);
  state_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] cap_q, cap_d;
  logic [3:0] frame_q, frame_d;
  logic fv_q, fv_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    frame_d = frame_q;
    fv_d    = fv_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SETTLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
      ST_SETTLE: if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
      else begin
        cnt_d = '0;
        if (sel_q != 2'd3) begin
          cap_d[sel_q] = y;
          sel_d        = sel_q + 2'd1;
        end else begin
          frame_d = {y, cap_q};
          fv_d    = 1'b1;
          sel_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: if (fv_q && frame_ready) begin
        fv_d    = 1'b0;
        cnt_d   = '0;
        sel_d   = '0;
        state_d = continuous ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
`ifdef MUX_SCAN_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else par_q <= ^frame_d;
  end
  assign frame_par = par_q;
`endif
  assign {s1, s0}    = sel_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = state_q != ST_IDLE;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl with SETTLE=2 and SETTLE=0 instances.
module tb_mux_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, continuous = 1'b0, ready = 1'b0;
  logic start0 = 1'b0, ready0 = 1'b1;
  logic [3:0] inp = 4'b0000, inp0 = 4'b0000;
  logic s1, s0, fv, busy, y, s1b, s0b, fvb, busyb, yb;
  logic [3:0] frame, frameb;
  logic par, parb;
  int n_chk = 0, n_fail = 0;
  logic [3:0] q[$], q0[$];
  always #5 clk = ~clk;
  assign y  = inp[{s1, s0}];
  assign yb = inp0[{s1b, s0b}];
  mux_scan_ctrl #(.SETTLE(2), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .y(y),
    .s1(s1), .s0(s0), .frame(frame), .frame_valid(fv), .frame_ready(ready), .busy(busy)
`ifdef MUX_SCAN_PARITY_EN
    , .frame_par(par)
`endif
  );
  mux_scan_ctrl #(.SETTLE(0), .CW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .continuous(1'b0), .y(yb),
    .s1(s1b), .s0(s0b), .frame(frameb), .frame_valid(fvb), .frame_ready(ready0), .busy(busyb)
`ifdef MUX_SCAN_PARITY_EN
    , .frame_par(parb)
`endif
  );
`ifndef MUX_SCAN_PARITY_EN
  assign par  = 1'b0;
  assign parb = 1'b0;
`endif
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && fv && ready) begin
          if (q.size() == 0) check("unexpected_frame", {4'h0, frame}, 8'hff);
          else begin
            logic [3:0] e;
            e = q.pop_front();
            check("frame", {4'h0, frame}, {4'h0, e});
`ifdef MUX_SCAN_PARITY_EN
            check("frame_par", {7'h0, par}, {7'h0, ^e});
`endif
          end
        end
        if (rst_n && fvb && ready0) begin
          if (q0.size() == 0) check("unexpected_frame0", {4'h0, frameb}, 8'hff);
          else begin
            logic [3:0] e;
            e = q0.pop_front();
            check("frame0", {4'h0, frameb}, {4'h0, e});
`ifdef MUX_SCAN_PARITY_EN
            check("frame_par0", {7'h0, parb}, {7'h0, ^e});
`endif
          end
        end
      end
    join_none
    #12;
    check("rst_outputs", {s1, s0, fv, busy, frame}, 8'h00);
    check("rst_par", {7'h0, par}, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    inp = 4'b1101;
    ready = 1'b1;
    q.push_back(4'b1101);
    pulse_start;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("single_sel_%0d", k), {6'h0, s1, s0}, 8'(k / 2));
      check($sformatf("single_fv_%0d", k), {6'h0, fv, busy}, 8'h01);
      tick(1);
    end
    check("single_fv_rise", {6'h0, fv, busy}, 8'h03);
    check("single_sel_hold", {6'h0, s1, s0}, 8'h00);
    tick(1);
    check("single_idle", {6'h0, fv, busy}, 8'h00);
    tick(3);
    ready = 1'b0;
    q.push_back(4'b1101);
    pulse_start;
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("bp_fv_timing", {6'h0, fv, busy}, 8'h03);
    inp = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold_%0d", k), {fv, s1, s0, frame}, {3'b100, 4'b1101});
      tick(1);
    end
    ready = 1'b1;
    tick(1);
    check("bp_release", {6'h0, fv, busy}, 8'h00);
    tick(10);
    check("ignored_start_one_frame", 8'(q.size()), 8'h00);
    inp = 4'b1101;
    continuous = 1'b1;
    q.push_back(4'b1101);
    q.push_back(4'b0110);
    q.push_back(4'b0110);
    pulse_start;
    tick(8);
    check("cont_f1", {7'h0, fv}, 8'h01);
    tick(1);
    inp = 4'b0110;
    check("cont_gap1", {6'h0, fv, busy}, 8'h01);
    tick(8);
    check("cont_f2", {7'h0, fv}, 8'h01);
    tick(1);
    check("cont_gap2", {6'h0, fv, busy}, 8'h01);
    tick(8);
    check("cont_f3", {7'h0, fv}, 8'h01);
    continuous = 1'b0;
    tick(1);
    check("cont_end", {6'h0, fv, busy}, 8'h00);
    check("cont_frames_done", 8'(q.size()), 8'h00);
    pulse_start;
    tick(4);
    check("midscan_sel", {6'h0, s1, s0}, 8'h02);
    rst_n = 1'b0;
    #1;
    check("midscan_rst", {s1, s0, fv, busy, frame}, 8'h00);
    check("midscan_rst_par", {7'h0, par}, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("post_rst_idle", {6'h0, fv, busy}, 8'h00);
    inp0 = 4'b0010;
    q0.push_back(4'b0010);
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("min_sel_%0d", k), {5'h0, fvb, s1b, s0b}, 8'(k));
      tick(1);
    end
    check("min_fv", {6'h0, fvb, busyb}, 8'h03);
    tick(1);
    check("min_idle", {6'h0, fvb, busyb}, 8'h00);
    check("min_frames_done", 8'(q0.size()), 8'h00);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
